// File: rtl/ex_muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide on magnitudes, one bit per cycle.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] opr_a,
    input  logic [DATA_WIDTH-1:0] opr_b,
    input  logic [RD_WIDTH-1:0]   rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [RD_WIDTH-1:0]   out_rd,
    output logic                  busy
);
    localparam int W         = DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT   = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [W-1:0]         MIN_SIGNED = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  is_div_q, is_div_d;
    logic                  sel_alt_q, sel_alt_d;   // MUL: take high half; DIV: take remainder
    logic                  neg_q, neg_d;
    logic [W-1:0]          hi_q, hi_d;
    logic [W-1:0]          lo_q, lo_d;
    logic [W-1:0]          mcand_q, mcand_d;
    logic [RD_WIDTH-1:0]   rd_q, rd_d;
    logic [W-1:0]          result_q, result_d;
    logic [RD_WIDTH-1:0]   out_rd_q, out_rd_d;

    // Operand decode at accept time
    logic          a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, fast;
    logic [W-1:0]  a_mag, b_mag, fast_res;

    always_comb begin
        a_sgn  = op[2] ? !op[0] : (op[1:0] != 2'b11);
        b_sgn  = op[2] ? !op[0] : !op[1];
        a_neg  = a_sgn & opr_a[W-1];
        b_neg  = b_sgn & opr_b[W-1];
        a_mag  = a_neg ? -opr_a : opr_a;
        b_mag  = b_neg ? -opr_b : opr_b;
        b_zero = (opr_b == '0);
        ovf    = op[2] && !op[0] && (opr_a == MIN_SIGNED) && (opr_b == '1);
        fast   = op[2] && (b_zero || ovf);
        if (b_zero) fast_res = op[1] ? opr_a : '1;
        else        fast_res = op[1] ? '0 : MIN_SIGNED;
    end

    // One iteration of each algorithm on the shared hi/lo/mcand registers
    logic [W:0]    mul_sum;
    logic [W-1:0]  mul_hi, mul_lo;
    logic [W:0]    div_shift;
    logic          div_ge;
    logic [W-1:0]  div_sub, div_hi, div_lo;
    logic [W-1:0]  iter_hi, iter_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        mul_hi    = mul_sum[W:1];
        mul_lo    = {mul_sum[0], lo_q[W-1:1]};
        div_shift = {hi_q, lo_q[W-1]};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        div_sub   = div_shift[W-1:0] - mcand_q;
        div_hi    = div_ge ? div_sub : div_shift[W-1:0];
        div_lo    = {lo_q[W-2:0], div_ge};
        iter_hi   = is_div_q ? div_hi : mul_hi;
        iter_lo   = is_div_q ? div_lo : mul_lo;
    end

    // Sign fix-up applied to the final iteration's value
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   div_val, fin_res;

    always_comb begin
        prod_s  = neg_q ? -{iter_hi, iter_lo} : {iter_hi, iter_lo};
        div_val = sel_alt_q ? iter_hi : iter_lo;
        if (is_div_q)       fin_res = neg_q ? -div_val : div_val;
        else if (sel_alt_q) fin_res = prod_s[2*W-1:W];
        else                fin_res = prod_s[W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        sel_alt_d = sel_alt_q;
        neg_d     = neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        rd_d      = rd_q;
        result_d  = result_q;
        out_rd_d  = out_rd_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (fast) begin
                            result_d = fast_res;
                            out_rd_d = rd;
                            state_d  = S_DONE;
                        end else begin
                            is_div_d  = op[2];
                            sel_alt_d = op[2] ? op[1] : (op[1:0] != 2'b00);
                            neg_d     = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
                            hi_d      = '0;
                            lo_d      = op[2] ? a_mag : b_mag;
                            mcand_d   = op[2] ? b_mag : a_mag;
                            rd_d      = rd;
                            cnt_d     = '0;
                            state_d   = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    hi_d = iter_hi;
                    lo_d = iter_lo;
                    if (cnt_q == LAST_CNT) begin
                        result_d = fin_res;
                        out_rd_d = rd_q;
                        cnt_d    = '0;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            sel_alt_q <= 1'b0;
            neg_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            out_rd_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            sel_alt_q <= sel_alt_d;
            neg_q     <= neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            out_rd_q  <= out_rd_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !flush;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: driver queues expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] opr_a = '0;
    logic [31:0] opr_b = '0;
    logic [4:0]  rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  out_rd;
    logic        busy;

    ex_muldiv_unit #(.DATA_WIDTH(32), .RD_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .opr_a(opr_a), .opr_b(opr_b), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_rd(out_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [4:0]  rd;
        int          acc_edge;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   edge_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    // Monitor: latency counts from the accept cycle to the first cycle out_valid is seen.
    initial begin
        logic prev_valid;
        int   valid_edge;
        exp_t e;
        prev_valid = 1'b0;
        valid_edge = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && !prev_valid) valid_edge = edge_cnt;
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out", {31'b0, out_valid}, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, "_result"}, result, e.res);
                        check({e.name, "_rd"}, {27'b0, out_rd}, {27'b0, e.rd});
                        check({e.name, "_latency"}, 32'(valid_edge - e.acc_edge + 1), 32'(e.lat));
                        $display("txn %s result=%h rd=%0d latency=%0d", e.name, result, out_rd,
                                 valid_edge - e.acc_edge + 1);
                    end
                end
            end
            prev_valid = out_valid && rst_n;
        end
    end

    task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r, input logic [31:0] er,
                         input int lat, input bit push);
        int   guard;
        exp_t e;
        @(negedge clk);
        op = o; opr_a = a; opr_b = b; rd = r; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout %s: in_ready=%b required 1", nm, in_ready);
            in_valid = 1'b0;
            return;
        end
        e.name = nm; e.res = er; e.rd = r; e.acc_edge = edge_cnt + 1; e.lat = lat;
        if (push) sb_q.push_back(e);
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the unit must hold its captured copy
        in_valid = 1'b0; op = 3'b011; opr_a = 32'hDEADBEEF; opr_b = 32'h0BADF00D; rd = 5'h1F;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || sb_q.size() != 0) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy=%b pending=%0d required 0", busy, sb_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_out_rd"}, {27'b0, out_rd}, 32'd0);
    endtask

    initial begin
        int g;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Iterative multiply and divide, issued back to back
        issue("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33, 1'b1);
        issue("MULH",   3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 33, 1'b1);
        issue("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 33, 1'b1);
        issue("MULHSU", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 33, 1'b1);
        issue("DIV",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33, 1'b1);
        issue("REM",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33, 1'b1);
        issue("DIVU",   3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       33, 1'b1);
        issue("REMU",   3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        33, 1'b1);
        // Fast path: divide by zero and signed overflow
        issue("DIVU_0", 3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1,  1'b1);
        issue("REM_0",  3'b110, 32'd5,        32'd0,        5'd14, 32'd5,        1,  1'b1);
        issue("DIV_OV", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1,  1'b1);
        issue("REM_OV", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1,  1'b1);
        wait_idle();

        // Back-pressure in DONE
        out_ready = 1'b0;
        issue("MUL_STALL", 3'b000, 32'h00012345, 32'h10, 5'd17, 32'h00123450, 33, 1'b1);
        g = 0;
        while (!out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("stall_reached_done", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_result", result, 32'h00123450);
            check("stall_out_rd", {27'b0, out_rd}, 32'd17);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            check("stall_busy", {31'b0, busy}, 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_busy", {31'b0, busy}, 32'd0);
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        check("release_out_valid", {31'b0, out_valid}, 32'd0);

        // Flush mid-divide: no result may appear
        issue("DIV_FLUSH", 3'b100, 32'd1000, 32'd3, 5'd18, 32'd333, 33, 1'b0);
        repeat (12) @(negedge clk);
        flush = 1'b1;
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        repeat (40) @(negedge clk);
        check("flush_still_idle", {31'b0, busy | out_valid}, 32'd0);

        // Async reset mid-multiply
        issue("MUL_RESET", 3'b000, 32'h1234, 32'h5678, 5'd19, 32'h06260060, 33, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        issue("MUL_3x4", 3'b000, 32'd3, 32'd4, 5'd3, 32'd12, 33, 1'b1);
        wait_idle();

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end
endmodule
